// File: rtl/alu_pkg.sv
// Shared ALU control codes and the iterative ALU state encoding.
// The ALU control decoder imports the same codes.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_iter_mul.sv
// Shift-add multiplier datapath: one partial product per step, WIDTH steps.
// sum is the accumulator value after the current step, used by the top on the last step.
module alu_iter_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] sum,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;

  assign sum  = acc + (mplier[0] ? mcand : '0);
  assign last = (count == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= multiplicand;
      mplier <= multiplier;
      count  <= CNT_W'(WIDTH);
    end else if (step && (count != '0)) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Iterative integer ALU: logic/add/compare in one cycle, shifts one bit per cycle,
// MUL via the shared shift-add datapath, with valid/ready on both sides.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SH_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [SH_W-1:0]  sh_cnt;
  logic [3:0]       sh_op;
  logic [SH_W-1:0]  shamt;
  logic             is_shift;
  logic             is_mul;
  logic             mul_load;
  logic             mul_step;
  logic             mul_last;
  logic [WIDTH-1:0] mul_sum;

  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] ctrl,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    case (ctrl)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_SUB:  return a - b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return {{(WIDTH-1){1'b0}}, (sa < sb)};
      ALU_SLTU: return {{(WIDTH-1){1'b0}}, (a < b)};
      default:  return a + b;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] r);
    logic signed [WIDTH-1:0] sr;
    sr = r;
    case (op)
      ALU_SLL: return r << 1;
      ALU_SRL: return r >> 1;
      default: return sr >>> 1;
    endcase
  endfunction

  assign shamt     = op_b[SH_W-1:0];
  assign is_shift  = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL) || (alu_ctrl == ALU_SRA);
  assign is_mul    = (alu_ctrl == ALU_MUL);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign zero      = (result == '0);
  assign mul_load  = in_ready && in_valid && is_mul;
  assign mul_step  = (state == S_MUL);

  alu_iter_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk          (clk),
    .rst          (rst),
    .load         (mul_load),
    .step         (mul_step),
    .multiplicand (op_a),
    .multiplier   (op_b),
    .sum          (mul_sum),
    .last         (mul_last)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mul)                           state_nx = S_MUL;
          else if (is_shift && (shamt != '0))   state_nx = S_SHIFT;
          else                                  state_nx = S_DONE;
        end
      end
      S_SHIFT: if (sh_cnt == SH_W'(1)) state_nx = S_DONE;
      S_MUL:   if (mul_last)           state_nx = S_DONE;
      S_DONE:  if (out_ready)          state_nx = S_IDLE;
      default:                         state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // result doubles as the shift register while an SLL/SRL/SRA is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      sh_cnt <= '0;
      sh_op  <= ALU_AND;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sh_op <= alu_ctrl;
            if (is_shift) begin
              result <= op_a;
              sh_cnt <= shamt;
            end else if (!is_mul) begin
              result <= alu_single(alu_ctrl, op_a, op_b);
            end
          end
        end
        S_SHIFT: begin
          result <= shift_one(sh_op, result);
          sh_cnt <= sh_cnt - SH_W'(1);
        end
        S_MUL: if (mul_last) result <= mul_sum;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: fixed vector table, random ops against a
// behavioural model, plus output-stall and reset-abort sequences.
module tb_alu_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           lat;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the operation table.
  function automatic logic [W-1:0] model_res(input logic [3:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    int unsigned sh;
    logic [63:0] prod;
    sh = b % W;
    prod = 64'(a) * 64'(b);
    case (c)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd3: return a - b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return W'($signed(a) >>> sh);
      4'd8: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd9: return (a < b) ? 1 : 0;
      4'd10: return prod[W-1:0];
      default: return a + b;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [W-1:0] b);
    if (c == 4'd10) return W + 1;
    if (c >= 4'd5 && c <= 4'd7) return (b % W) + 1;
    return 1;
  endfunction

  // Issue one op (called #1 after a rising edge), wait for completion, check it.
  task automatic run_op(input string name, input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_lat);
    int lat;
    check({name, " in_ready before"}, 64'(in_ready), 64'd1);
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, 64'(result), 64'(exp_res));
    check({name, " zero"}, 64'(zero), 64'(exp_res == '0));
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    logic [W-1:0] held;
    tbl[0]  = '{4'b0010, 32'd5,          32'd7,          32'd12,         1};
    tbl[1]  = '{4'b0011, 32'd9,          32'd9,          32'd0,          1};
    tbl[2]  = '{4'b1000, 32'hFFFFFFFF,   32'd1,          32'd1,          1};
    tbl[3]  = '{4'b1001, 32'hFFFFFFFF,   32'd1,          32'd0,          1};
    tbl[4]  = '{4'b0111, 32'h80000000,   32'd4,          32'hF8000000,   5};
    tbl[5]  = '{4'b0111, 32'h80000000,   32'd0,          32'h80000000,   1};
    tbl[6]  = '{4'b1010, 32'h00012345,   32'h10,         32'h00123450,   33};
    tbl[7]  = '{4'b0000, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000,   1};
    tbl[8]  = '{4'b0001, 32'hF0F0F0F0,   32'hFF00FF00,   32'hFFF0FFF0,   1};
    tbl[9]  = '{4'b0100, 32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0,   1};
    tbl[10] = '{4'b0101, 32'd1,          32'd31,         32'h80000000,   32};
    tbl[11] = '{4'b0110, 32'h80000000,   32'd31,         32'd1,          32};
    tbl[12] = '{4'b1111, 32'd3,          32'd4,          32'd7,          1};
    tbl[13] = '{4'b0101, 32'd1,          32'h21,         32'd2,          2};
    tbl[14] = '{4'b0010, 32'hFFFFFFFF,   32'd1,          32'd0,          1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset zero", 64'(zero), 64'd1);
    check("reset in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] c;
      logic [W-1:0] a, b;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : $urandom;
      run_op($sformatf("rnd%0d", i), c, a, b, model_res(c, a, b), model_lat(c, b));
    end

    // Output stall: DONE holds result and refuses new ops.
    out_ready = 1'b0;
    alu_ctrl = 4'b1010; op_a = 32'h00012345; op_b = 32'h10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("stall latency", 64'(k), 64'd33);
    held = result;
    check("stall result", 64'(held), 64'h123450);
    alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("stall%0d result", i), 64'(result), 64'(held));
      check($sformatf("stall%0d in_ready", i), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall release out_valid", 64'(out_valid), 64'd0);
    check("stall release in_ready", 64'(in_ready), 64'd1);

    // Reset abort in the middle of a MUL, with a competing op on in_valid.
    alu_ctrl = 4'b1010; op_a = 32'h7; op_b = 32'h9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort pre in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort result", 64'(result), 64'd0);
    check("abort zero", 64'(zero), 64'd1);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) k++;
    end
    check("abort no output", 64'(k), 64'd0);
    run_op("after abort", 4'b0011, 32'd10, 32'd3, 32'd7, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
